// File: rtl/fixed_requant_pkg.sv
// Shared constants and helpers for the fixed-point requantiser.
// Optional feature macro: FIXED_REQUANT_SAT_COUNT_EN (saturation counter).
package fixed_requant_pkg;

  localparam int RQ_WORD_W = 64;

  // Widest stage-1 lane word; each pipeline register keeps the low IW bits of it.
  typedef logic signed [RQ_WORD_W-1:0] rq_word_t;

  function automatic int rq_shift(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  function automatic int rq_iw(input int in_w, input int in_frac, input int out_frac);
    int sh;
    sh = rq_shift(in_frac, out_frac);
    return in_w + ((sh < 0) ? -sh : 0) + 1;
  endfunction

  function automatic rq_word_t rq_sat_max(input int out_w);
    return (rq_word_t'(1) <<< (out_w - 1)) - rq_word_t'(1);
  endfunction

  function automatic rq_word_t rq_sat_min(input int out_w);
    return -(rq_word_t'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fixed_requant_lane.sv
// One lane of the requantiser: combinational round (into stage 1) and saturate (out of stage 1).
// Optional feature macro: FIXED_REQUANT_SAT_COUNT_EN adds the sat_o flag.
module fixed_requant_lane
  import fixed_requant_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int IN_FRAC  = 4,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 2,
  parameter int SH       = rq_shift(IN_FRAC, OUT_FRAC),
  parameter int IW       = rq_iw(IN_W, IN_FRAC, OUT_FRAC)
) (
  input  logic [IN_W-1:0]  x_i,
  output logic [IW-1:0]    r_o,
  input  logic [IW-1:0]    r_i,
  output logic [OUT_W-1:0] y_o
`ifdef FIXED_REQUANT_SAT_COUNT_EN
  ,
  output logic             sat_o
`endif
);

  logic signed [IW-1:0] xe;
  logic signed [IW-1:0] rs;

  assign xe = {{(IW-IN_W){x_i[IN_W-1]}}, x_i};
  assign rs = r_i;

  // The extra headroom bit in IW keeps x + half from overflowing before the shift.
  if (SH > 0) begin : g_rnd_down
    localparam logic signed [IW-1:0] HALF = IW'(64'd1 << (SH - 1));
    assign r_o = (xe + HALF) >>> SH;
  end else if (SH == 0) begin : g_rnd_pass
    assign r_o = xe;
  end else begin : g_rnd_up
    assign r_o = xe <<< (-SH);
  end

  if (IW > OUT_W) begin : g_sat
    localparam logic signed [IW-1:0] SMAX = IW'(rq_sat_max(OUT_W));
    localparam logic signed [IW-1:0] SMIN = IW'(rq_sat_min(OUT_W));
    assign y_o = (rs > SMAX) ? SMAX[OUT_W-1:0] :
                 (rs < SMIN) ? SMIN[OUT_W-1:0] : r_i[OUT_W-1:0];
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    assign sat_o = (rs > SMAX) || (rs < SMIN);
`endif
  end else begin : g_nosat
    // Output is at least as wide as the rounded value, so it can never clip.
    assign y_o = OUT_W'(rs);
`ifdef FIXED_REQUANT_SAT_COUNT_EN
    assign sat_o = 1'b0;
`endif
  end

endmodule

// File: rtl/fixed_requant_stream.sv
// Two-stage streaming requantiser (round, then saturate) with valid/ready backpressure.
// Optional feature macro: FIXED_REQUANT_SAT_COUNT_EN builds the sticky saturation counter.
module fixed_requant_stream
  import fixed_requant_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0      = 8,
  parameter int DATA_IN_0_PRECISION_1      = 4,
  parameter int DATA_OUT_0_PRECISION_0     = 8,
  parameter int DATA_OUT_0_PRECISION_1     = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SAT_COUNT_W                = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0][DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  output logic [SAT_COUNT_W-1:0] sat_count
);

  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int IW    = rq_iw(IN_W, DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);

  logic                     v1_q, v1_d, v2_q, v2_d;
  logic [N-1:0][IW-1:0]     s1_q, s1_d, r_w;
  logic [N-1:0][OUT_W-1:0]  s2_q, s2_d, y_w;
  logic                     ld1, ld2;
`ifdef FIXED_REQUANT_SAT_COUNT_EN
  logic [N-1:0]             sat_w;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    fixed_requant_lane #(
      .IN_W    (IN_W),
      .IN_FRAC (DATA_IN_0_PRECISION_1),
      .OUT_W   (OUT_W),
      .OUT_FRAC(DATA_OUT_0_PRECISION_1)
    ) u_lane (
      .x_i  (data_in_0[i]),
      .r_o  (r_w[i]),
      .r_i  (s1_q[i]),
      .y_o  (y_w[i])
`ifdef FIXED_REQUANT_SAT_COUNT_EN
      ,
      .sat_o(sat_w[i])
`endif
    );
  end

  // Stage 1 may refill in the same cycle its beat advances, giving full throughput.
  always_comb begin
    ld2  = !v2_q || data_out_0_ready;
    ld1  = !v1_q || ld2;
    v1_d = v1_q;
    s1_d = s1_q;
    v2_d = v2_q;
    s2_d = s2_q;
    if (ld1) begin
      v1_d = data_in_0_valid;
      if (data_in_0_valid) s1_d = r_w;
    end
    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) s2_d = y_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign data_in_0_ready  = ld1;
  assign data_out_0_valid = v2_q;
  assign data_out_0       = s2_q;

`ifdef FIXED_REQUANT_SAT_COUNT_EN
  localparam int PW = $clog2(N + 1);
  localparam int CW = SAT_COUNT_W + PW;

  logic [PW-1:0]          pop;
  logic [CW-1:0]          sum;
  logic [SAT_COUNT_W-1:0] cnt_q, cnt_d;

  // Counter sticks at all-ones rather than wrapping.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + PW'(sat_w[i]);
    sum   = CW'(cnt_q) + CW'(pop);
    cnt_d = cnt_q;
    if (ld2 && v1_q)
      cnt_d = (sum > CW'({SAT_COUNT_W{1'b1}})) ? {SAT_COUNT_W{1'b1}} : sum[SAT_COUNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: doc/fixed_requant_stream.md
# fixed_requant_stream

Streaming fixed-point requantiser placed directly downstream of the fixed-point activation stages (hardshrink, ReLU and similar). It converts each lane from the activation's output precision to the next layer's input precision. Rounding is round-to-nearest with ties toward +inf, and the result saturates to the signed output range. It is a 2-stage pipeline with full valid/ready backpressure, so activations that pass data through combinationally gain a registered boundary.

## Interface
Parameters:
- DATA_IN_0_PRECISION_0, 8, input total width (signed two's complement)
- DATA_IN_0_PRECISION_1, 4, input fractional bits
- DATA_OUT_0_PRECISION_0, 8, output total width
- DATA_OUT_0_PRECISION_1, 2, output fractional bits
- DATA_IN_0_PARALLELISM_DIM_0, 1, lanes per beat, dim 0
- DATA_IN_0_PARALLELISM_DIM_1, 1, lanes per beat, dim 1; N = DIM_0*DIM_1
- SAT_COUNT_W, 16, saturation counter width

Ports:
- clk, in, 1, clock; one clock domain, all logic on the rising edge
- rst, in, 1, reset; synchronous, active-high
- data_in_0, in, [DATA_IN_0_PRECISION_0-1:0] x N, input lanes
- data_in_0_valid, in, 1, input beat valid
- data_in_0_ready, out, 1, block can accept a beat this cycle
- data_out_0, out, [DATA_OUT_0_PRECISION_0-1:0] x N, requantised lanes
- data_out_0_valid, out, 1, output beat valid
- data_out_0_ready, in, 1, downstream accepts
- sat_count, out, SAT_COUNT_W, cumulative count of saturated lanes

## Operation
- Definitions: SH = IN_FRAC - OUT_FRAC (signed constant); IW = IN_W + max(0, -SH) + 1.
- Stage 1 (round), per lane, into a width-IW register:
  - SH > 0: r = (x + 2^(SH-1)) >>> SH, arithmetic shift.
  - SH = 0: r = x, sign-extended.
  - SH < 0: r = x <<< -SH.
- Stage 2 (saturate), per lane:
  - r > 2^(OUT_W-1)-1 gives 2^(OUT_W-1)-1, with sat flag set.
  - r < -2^(OUT_W-1) gives -2^(OUT_W-1), with sat flag set.
  - Otherwise the low OUT_W bits of r.
- All beats travel through both stages with no bypass. Lane order and beat order are preserved.
- Stage 1 loads when it is empty or its contents move to stage 2 in the same cycle.
- Stage 2 loads when it is empty or data_out_0_ready is high.
- data_in_0_ready = !v1 || !v2 || data_out_0_ready. This is a combinational path from data_out_0_ready, which is permitted.
- No beat is ever dropped or duplicated. data_out_0 and data_out_0_valid are held stable while valid && !ready.

## Timing
- Latency: 2 cycles from input handshake to data_out_0_valid, with no stalls.
- Throughput: 1 beat per cycle while data_out_0_ready stays high.
- Capacity: 2 beats. When both stages are full and data_out_0_ready is low, data_in_0_ready is low.
- Simultaneous accept and emit with both stages full: stage 2 takes stage 1's contents, and stage 1 takes the new input in the same cycle.
- Reset, including in the middle of a stream: on the next edge v1, v2, data_out_0_valid and sat_count go to 0, and stage data registers and data_out_0 go to 0. In-flight beats are discarded. data_in_0_ready is high in the first cycle after reset deasserts.

## Configuration
- Macro FIXED_REQUANT_SAT_COUNT_EN.
- Defined:
  - When stage 2 loads a beat, sat_count increments by the popcount of that beat's N sat flags.
  - The counter sticks at its maximum value (2^SAT_COUNT_W - 1) and never wraps.
- Undefined: sat flags and the counter are not built, and sat_count is tied to 0. Datapath behaviour is identical in both builds.

## Structure
- Package fixed_requant_pkg:
  - Function to compute SH, IW and the saturation bounds from the precision parameters.
  - Typedef for the stage-1 lane word.
- Sub-module fixed_requant_lane: combinational round-and-saturate for one lane. The top instantiates N of them and owns the pipeline registers, handshake and counter.

## Test plan
- IN 8/4, OUT 8/2, ready held high: 0x17 (1.4375) produces 0x06 (1.5) two cycles later.
- Ties: 0x02 (0.125) produces 0x01. 0xFE (-0.125) produces 0x00.
- Saturation, OUT 4/2: 0x7F produces 0x7 and 0x80 produces 0x8. With the macro defined, sat_count = 2.
- Backpressure: stream 10 beats with data_out_0_ready low for cycles 3-7. data_in_0_ready drops after 2 stalled beats, and all 10 beats emerge in order with no loss.
- Reset with both stages full: next cycle data_out_0_valid = 0 and sat_count = 0, and a fresh beat afterwards shows 2-cycle latency.
- Counter ceiling, SAT_COUNT_W = 4, N = 2: 10 fully saturating beats leave sat_count = 15.
